// File: rtl/nn_pkg.sv
// Shared types for the neural-network layer plumbing.
// The serializer state enum lives here so that any block that reports or
// decodes serializer state uses the same encoding.
package nn_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

endpackage

// File: rtl/frame_buffer.sv
// Single-entry parallel holding register for one whole layer frame.
// A load and a take in the same cycle leave the entry full with the new frame.
module frame_buffer #(
   parameter int FRAME_W = 480
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               i_load,
   input  logic               i_take,
   input  logic [FRAME_W-1:0] i_data,
   output logic               o_full,
   output logic [FRAME_W-1:0] o_data
);

   logic               r_full;
   logic [FRAME_W-1:0] r_data;

   // Occupancy flag: load wins over take so a swap keeps the entry full.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_full <= 1'b0;
      end else if (i_load) begin
         r_full <= 1'b1;
      end else if (i_take) begin
         r_full <= 1'b0;
      end
   end

   // Frame payload; only meaningful while r_full is set, so it needs no reset.
   always_ff @(posedge clk) begin
      if (i_load) begin
         r_data <= i_data;
      end
   end

   assign o_full = r_full;
   assign o_data = r_data;

endmodule

// File: rtl/layer_serializer.sv
// Inter-layer serializer: captures all neuron outputs of a layer in parallel
// and streams them one word per cycle (neuron 0 first) to the next layer.
// A one-frame pending buffer absorbs a result that arrives mid-stream.
module layer_serializer
   import nn_pkg::*;
#(
   parameter int numNeurons = 30,
   parameter int dataWidth  = 16
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [numNeurons*dataWidth-1:0] neuron_data,
   input  logic [numNeurons-1:0]           neuron_valid,
   input  logic                            out_ready,
   input  logic                            clear_err,
   output logic [dataWidth-1:0]            mOutput,
   output logic                            mOutputValid,
   output logic                            mOutputLast,
   output logic                            busy,
   output logic                            err_overrun,
   output logic                            err_misalign
);

   localparam int FRAME_W = numNeurons * dataWidth;
   localparam int CNT_W   = $clog2(numNeurons);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(numNeurons - 1);

   ser_state_t         r_state;
   logic [CNT_W-1:0]   r_beat_cnt;
   logic [FRAME_W-1:0] r_active;
   logic               r_err_overrun;
   logic               r_err_misalign;

   logic               w_capture;
   logic               w_misalign;
   logic               w_xfer;
   logic               w_finish;
   logic               w_overrun;
   logic               w_pend_load;
   logic               w_pend_take;
   logic               w_pend_full;
   logic [FRAME_W-1:0] w_pend_data;
   logic [FRAME_W-1:0] w_shifted;

   // Only neuron 0's valid triggers capture; the rest are used for the alignment check.
   assign w_capture  = neuron_valid[0];
   assign w_misalign = (neuron_valid != '0) && (neuron_valid != '1);
   assign w_xfer     = (r_state == SHIFT) && out_ready;
   assign w_finish   = w_xfer && (r_beat_cnt == LAST_BEAT);
   assign w_shifted  = {{dataWidth{1'b0}}, r_active[FRAME_W-1:dataWidth]};

   frame_buffer #(
      .FRAME_W (FRAME_W)
   ) u_pending (
      .clk    (clk),
      .rstn   (rstn),
      .i_load (w_pend_load),
      .i_take (w_pend_take),
      .i_data (neuron_data),
      .o_full (w_pend_full),
      .o_data (w_pend_data)
   );

   // Pending-buffer control: park a mid-stream frame, hand it over on the final
   // beat (accepting a coincident new frame into the freed slot), else flag overrun.
   always_comb begin
      w_pend_load = 1'b0;
      w_pend_take = 1'b0;
      w_overrun   = 1'b0;
      if (r_state == SHIFT) begin
         if (w_finish) begin
            if (w_pend_full) begin
               w_pend_take = 1'b1;
               w_pend_load = w_capture;
            end
         end else if (w_capture) begin
            if (w_pend_full) begin
               w_overrun = 1'b1;
            end else begin
               w_pend_load = 1'b1;
            end
         end
      end
   end

   // Stream state machine: owns the active shift register and beat counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_beat_cnt <= '0;
         r_active   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_capture) begin
                  r_active   <= neuron_data;
                  r_beat_cnt <= '0;
                  r_state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_finish) begin
                  r_beat_cnt <= '0;
                  if (w_pend_full) begin
                     r_active <= w_pend_data;
                  end else if (w_capture) begin
                     r_active <= neuron_data;
                  end else begin
                     r_active <= w_shifted;
                     r_state  <= IDLE;
                  end
               end else if (w_xfer) begin
                  r_active   <= w_shifted;
                  r_beat_cnt <= r_beat_cnt + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Sticky error flags; a new error in the same cycle beats a clear request.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_err_overrun  <= 1'b0;
         r_err_misalign <= 1'b0;
      end else begin
         if (w_overrun) begin
            r_err_overrun <= 1'b1;
         end else if (clear_err) begin
            r_err_overrun <= 1'b0;
         end
         if (w_misalign) begin
            r_err_misalign <= 1'b1;
         end else if (clear_err) begin
            r_err_misalign <= 1'b0;
         end
      end
   end

   assign mOutput      = r_active[dataWidth-1:0];
   assign mOutputValid = (r_state == SHIFT);
   assign mOutputLast  = (r_state == SHIFT) && (r_beat_cnt == LAST_BEAT);
   assign busy         = (r_state == SHIFT) || w_pend_full;
   assign err_overrun  = r_err_overrun;
   assign err_misalign = r_err_misalign;

endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer (4 neurons x 16 bits): directed scenarios with
// literal expectations, then randomized traffic against a frame-queue model.
module tb_layer_serializer;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int FW = N * W;

   logic          clk = 1'b0;
   logic          rstn;
   logic [FW-1:0] neuron_data;
   logic [N-1:0]  neuron_valid;
   logic          out_ready;
   logic          clear_err;
   logic [W-1:0]  mOutput;
   logic          mOutputValid;
   logic          mOutputLast;
   logic          busy;
   logic          err_overrun;
   logic          err_misalign;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   layer_serializer #(
      .numNeurons (N),
      .dataWidth  (W)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .neuron_data  (neuron_data),
      .neuron_valid (neuron_valid),
      .out_ready    (out_ready),
      .clear_err    (clear_err),
      .mOutput      (mOutput),
      .mOutputValid (mOutputValid),
      .mOutputLast  (mOutputLast),
      .busy         (busy),
      .err_overrun  (err_overrun),
      .err_misalign (err_misalign)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_q holds accepted frames in stream order: entry 0 is being sent, entry 1
   // is the waiting one. m_pos is the index of the word currently presented.
   logic [FW-1:0] m_q[$];
   int            m_pos;
   bit            m_ov;
   bit            m_mis;
   bit            m_cap;
   bit            m_xfer;
   bit            m_ovr_now;
   bit            m_mis_now;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_q.delete();
         m_pos = 0;
         m_ov  = 1'b0;
         m_mis = 1'b0;
      end else begin
         m_mis_now = (neuron_valid != '0) && (neuron_valid != '1);
         m_cap     = neuron_valid[0];
         m_xfer    = (m_q.size() > 0) && out_ready;
         m_ovr_now = 1'b0;
         if (m_xfer) begin
            if (m_pos == N - 1) begin
               void'(m_q.pop_front());
               m_pos = 0;
            end else begin
               m_pos++;
            end
         end
         if (m_cap) begin
            if (m_q.size() < 2) m_q.push_back(neuron_data);
            else m_ovr_now = 1'b1;
         end
         if (m_ovr_now) m_ov = 1'b1;
         else if (clear_err) m_ov = 1'b0;
         if (m_mis_now) m_mis = 1'b1;
         else if (clear_err) m_mis = 1'b0;
      end
   end

   // ---------------- per-cycle comparison ----------------
   bit            chk_en = 1'b0;
   bit            e_valid;
   logic [FW-1:0] e_frame;

   always @(negedge clk) begin
      if (chk_en) begin
         e_valid = (m_q.size() > 0);
         check("valid", 32'(mOutputValid), 32'(e_valid));
         check("busy", 32'(busy), 32'(e_valid));
         check("last", 32'(mOutputLast), 32'(e_valid && (m_pos == N - 1)));
         if (e_valid) begin
            e_frame = m_q[0];
            check("word", 32'(mOutput), 32'(e_frame[m_pos*W +: W]));
         end else if (!rstn) begin
            check("word_rst", 32'(mOutput), 32'd0);
         end
         check("err_overrun", 32'(err_overrun), 32'(m_ov));
         check("err_misalign", 32'(err_misalign), 32'(m_mis));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic [N-1:0] v, input logic [FW-1:0] d,
                      input logic rdy, input logic clr);
      neuron_valid = v;
      neuron_data  = d;
      out_ready    = rdy;
      clear_err    = clr;
      @(posedge clk);
      #1;
      neuron_valid = '0;
      clear_err    = 1'b0;
      out_ready    = 1'b1;
   endtask

   task automatic idle();
      cyc('0, {$urandom(), $urandom()}, 1'b1, 1'b0);
   endtask

   task automatic expect_word(input string name, input int word, input bit last);
      check({name, "_valid"}, 32'(mOutputValid), 32'd1);
      check({name, "_word"}, 32'(mOutput), 32'(word));
      check({name, "_last"}, 32'(mOutputLast), 32'(last));
   endtask

   localparam logic [FW-1:0] FA = {16'd4, 16'd3, 16'd2, 16'd1};
   localparam logic [FW-1:0] FB = {16'd8, 16'd7, 16'd6, 16'd5};
   localparam logic [FW-1:0] FC = {16'd12, 16'd11, 16'd10, 16'd9};

   int            rate;
   logic [N-1:0]  rv;

   initial begin
      rstn         = 1'b0;
      neuron_valid = '0;
      neuron_data  = '0;
      out_ready    = 1'b1;
      clear_err    = 1'b0;
      chk_en       = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("rst_valid", 32'(mOutputValid), 32'd0);
      check("rst_word", 32'(mOutput), 32'd0);
      check("rst_last", 32'(mOutputLast), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_errs", 32'({err_overrun, err_misalign}), 32'd0);
      rstn = 1'b1;
      idle();

      // Single frame, words 1..4, last only on 4, then idle
      cyc('1, FA, 1'b1, 1'b0);  expect_word("t1_w1", 1, 1'b0);
      idle();                   expect_word("t1_w2", 2, 1'b0);
      idle();                   expect_word("t1_w3", 3, 1'b0);
      idle();                   expect_word("t1_w4", 4, 1'b1);
      idle();
      check("t1_idle_valid", 32'(mOutputValid), 32'd0);
      check("t1_idle_busy", 32'(busy), 32'd0);

      // Pending frame streams with no bubble; third frame overruns
      cyc('1, FA, 1'b1, 1'b0);  expect_word("t2_w1", 1, 1'b0);
      idle();                   expect_word("t2_w2", 2, 1'b0);
      cyc('1, FB, 1'b1, 1'b0);  expect_word("t2_w3", 3, 1'b0);
      check("t2_busy", 32'(busy), 32'd1);
      check("t2_no_err", 32'(err_overrun), 32'd0);
      cyc('1, FC, 1'b1, 1'b0);  expect_word("t2_w4", 4, 1'b1);
      check("t3_overrun", 32'(err_overrun), 32'd1);
      idle();                   expect_word("t2_w5", 5, 1'b0);
      idle();                   expect_word("t2_w6", 6, 1'b0);
      idle();                   expect_word("t2_w7", 7, 1'b0);
      idle();                   expect_word("t2_w8", 8, 1'b1);
      idle();
      check("t3_dropped", 32'(mOutputValid), 32'd0);
      check("t3_sticky", 32'(err_overrun), 32'd1);
      cyc('0, '0, 1'b1, 1'b1);
      check("t3_cleared", 32'(err_overrun), 32'd0);

      // Backpressure holds the presented word
      cyc('1, FA, 1'b1, 1'b0);         expect_word("t4_w1", 1, 1'b0);
      cyc('0, '0, 1'b1, 1'b0);         expect_word("t4_w2", 2, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);         expect_word("t4_hold1", 2, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);         expect_word("t4_hold2", 2, 1'b0);
      cyc('0, '0, 1'b1, 1'b0);         expect_word("t4_w3", 3, 1'b0);
      cyc('0, '0, 1'b0, 1'b0);         expect_word("t4_hold3", 3, 1'b0);
      idle();                          expect_word("t4_w4", 4, 1'b1);
      cyc('0, '0, 1'b0, 1'b0);         expect_word("t4_hold4", 4, 1'b1);
      idle();
      check("t4_done", 32'(mOutputValid), 32'd0);

      // Capture on the final beat, pending empty: no gap
      cyc('1, FA, 1'b1, 1'b0);  expect_word("t5_w1", 1, 1'b0);
      idle();                   expect_word("t5_w2", 2, 1'b0);
      idle();                   expect_word("t5_w3", 3, 1'b0);
      idle();                   expect_word("t5_w4", 4, 1'b1);
      cyc('1, FB, 1'b1, 1'b0);  expect_word("t5_w5", 5, 1'b0);
      idle();                   expect_word("t5_w6", 6, 1'b0);
      idle();                   expect_word("t5_w7", 7, 1'b0);
      idle();                   expect_word("t5_w8", 8, 1'b1);
      idle();
      check("t5_done", 32'(mOutputValid), 32'd0);

      // Misaligned valid still captures; reset mid-frame wipes everything
      cyc(4'b0011, FC, 1'b1, 1'b0);
      expect_word("t6_w9", 9, 1'b0);
      check("t6_misalign", 32'(err_misalign), 32'd1);
      cyc(4'b1111, FA, 1'b1, 1'b0);  expect_word("t6_w10", 10, 1'b0);
      rstn = 1'b0;
      #1;
      check("t6_rst_valid", 32'(mOutputValid), 32'd0);
      check("t6_rst_word", 32'(mOutput), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_errs", 32'({err_overrun, err_misalign}), 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (6) idle();
      check("t6_no_residual", 32'(mOutputValid), 32'd0);

      // Randomized traffic with varying capture rate, backpressure and clears
      for (int i = 0; i < 4000; i++) begin
         rate = ((i / 400) % 4) + 2;
         rv   = ($urandom_range(0, rate - 1) == 0) ? '1 : '0;
         if ($urandom_range(0, 40) == 0) rv = N'($urandom());
         if ($urandom_range(0, 900) == 0) begin
            rstn = 1'b0;
            @(posedge clk);
            #1;
            rstn = 1'b1;
         end
         cyc(rv, {$urandom(), $urandom()}, ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 30) == 0));
      end
      repeat (12) idle();

      @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/layer_serializer.md
# layer_serializer

Inter-layer stage between a layer of `neuron` instances and the next layer. It captures the parallel outputs of all `numNeurons` neurons when they assert valid together, then emits them one per cycle as an `mOutput`/`mOutputValid` stream. The stream feeds the broadcast `mInput`/`mInputValid` bus of the next layer, whose `numWeight` must equal `numNeurons`. A one-frame pending buffer absorbs a new layer result that arrives while the previous frame is still being streamed.

## Interface
- `numNeurons`, default 30: neurons in the upstream layer, which is also the frame length. Must be ≥2.
- `dataWidth`, default 16: width of each neuron output word.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `neuron_data`  in  `numNeurons*dataWidth`: flattened neuron outputs; neuron k occupies `[k*dataWidth +: dataWidth]`.
- `neuron_valid`  in  `numNeurons`: per-neuron `mOutputValid` pulses.
- `out_ready`  in  1: downstream accept. Tie to 1 when feeding neurons, which have no backpressure.
- `clear_err`  in  1: synchronous clear of the sticky error flags.
- `mOutput`  out  `dataWidth`: current stream word.
- `mOutputValid`  out  1: stream word valid.
- `mOutputLast`  out  1: high with the final word (neuron `numNeurons-1`) of a frame.
- `busy`  out  1: high in SHIFT or while the pending buffer is full.
- `err_overrun`  out  1: sticky; a frame arrived while both buffers were occupied.
- `err_misalign`  out  1: sticky; `neuron_valid` was neither all-0 nor all-1 in some cycle.

## Operation
- **Capture event:** `neuron_valid[0]==1`. Only bit 0 is the trigger. Any cycle where `neuron_valid` is neither all-0 nor all-1 sets `err_misalign`; the capture still follows bit 0.
- **Active buffer:** a `numNeurons*dataWidth` shift register. `mOutput` = its low word.
- **Transfer:** a beat completes when `mOutputValid & out_ready`. On a transfer the buffer shifts right by `dataWidth` and `beat_cnt` increments.
- **State machine:** states IDLE and SHIFT.
  - IDLE + capture → load active from `neuron_data`, `beat_cnt`=0, go to SHIFT.
  - SHIFT + transfer with `beat_cnt==numNeurons-1`:
    - pending full → load active from pending, clear pending, stay in SHIFT.
    - else, capture in the same cycle → load active from `neuron_data`, stay in SHIFT.
    - else → go to IDLE.
  - SHIFT + capture, not completing the last beat: pending empty → store in pending. Pending full → drop the new frame and set `err_overrun`.
  - Final-beat cycle with pending full and a capture: pending is moved to active, the new frame goes into pending, and no error is raised.
- **Outputs:**
  - `mOutputValid` = (state==SHIFT).
  - `mOutputLast` = SHIFT & `beat_cnt==numNeurons-1`.
  - While `out_ready`=0, `mOutput`, `mOutputValid` and `mOutputLast` hold unchanged.
- **Errors:** set has priority over `clear_err` in the same cycle.
- **Data:** words pass through unmodified; no arithmetic, no sign handling.

## Timing
- **Reset values:**
  - state IDLE, `beat_cnt` 0, pending empty.
  - `mOutput` 0, `mOutputValid` 0, `mOutputLast` 0.
  - `busy` 0, `err_overrun` 0, `err_misalign` 0.
  - Reset mid-frame discards both active and pending frames immediately.
- **Latency:** capture at edge t → first word valid in cycle t+1. With `out_ready`=1, word k is valid in cycle t+1+k and last in cycle t+`numNeurons`.
- **Back-to-back:** frames issued from pending, or captured on the final-beat edge, stream with zero bubble.
- **Cadence:** with `out_ready`=1 the block sustains one frame per `numNeurons` cycles. The upstream layer's period (≈`numWeight`+6 cycles) must be ≥ `numNeurons`, otherwise overrun is expected.
- **Outputs:** all registered, or derived only from registered state.
- **Errors:** flags assert the cycle after the offending event.

## Structure
- **Shared package:** `nn_pkg` holds the `ser_state_t` enum (IDLE, SHIFT).
- **Sub-module:** one natural sub-module, `frame_buffer`. It is a single-entry parallel holding register with `load`, `take`, `full` and `data`, used for the pending stage.
- **Counter width:** `beat_cnt` is `$clog2(numNeurons)` bits. Wrap is never used; the counter is reloaded to 0 on every frame load.

## Test plan
1. `numNeurons`=4, `dataWidth`=16, capture {4,3,2,1} (neuron0=1), `out_ready`=1 → `mOutput` 1,2,3,4 in cycles t+1..t+4, `mOutputLast` only on 4, then IDLE.
2. Second capture {8,7,6,5} at t+2 → after word 4 at t+4, word 5 at t+5 with no bubble; `busy` high throughout; no error.
3. Third capture at t+3 while pending is full → frame dropped, `err_overrun`=1 from t+4, stays set until `clear_err`.
4. `out_ready` toggled 1,0,0,1 during a frame → `mOutput` holds its word while low; all 4 words delivered in order, none duplicated.
5. Capture coincident with the final beat, pending empty → new frame word0 in the next cycle; `mOutputValid` never drops.
6. `neuron_valid`=4'b0011 → `err_misalign` set, frame still captured; `rstn` low mid-frame → all outputs 0 next cycle, no residual words after reset release.
